// File: rtl/demux4_tdm_if.sv
// demux4_tdm_if: serial TDM link plus recovered parallel channels.
//   master : drives en/din/frame, observes the recovered outputs
//   slave  : the demultiplexer side (demux4_tdm)
// Signals:
//   en, din, frame        slot enable, serial bit, slot-0 strobe
//   out_a..out_d          channel bits from the last complete frame
//   valid, err            one-cycle frame-complete / alignment-error pulses
//   locked                high while aligned
//   sel                   mux4-encoded current slot (a=00 b=10 c=01 d=11)
interface demux4_tdm_if;
  logic       en;
  logic       din;
  logic       frame;
  logic       out_a;
  logic       out_b;
  logic       out_c;
  logic       out_d;
  logic       valid;
  logic       err;
  logic       locked;
  logic [1:0] sel;

  modport master (
    output en, din, frame,
    input  out_a, out_b, out_c, out_d, valid, err, locked, sel
  );

  modport slave (
    input  en, din, frame,
    output out_a, out_b, out_c, out_d, valid, err, locked, sel
  );
endinterface

// File: rtl/demux4_tdm.sv
// demux4_tdm: 4-slot, 1-bit time-division demultiplexer.
// Recovers frame alignment from the frame strobe, collects slots a..c in
// shadow registers and publishes all four channels when slot d arrives.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset (priority over everything)
//   bus    demux4_tdm_if.slave (serial in, parallel out, status)
module demux4_tdm (
  input  logic          clk,
  input  logic          reset,
  demux4_tdm_if.slave   bus
);

  typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} state_t;

  state_t     state;
  logic [1:0] slot;
  logic       sh_a, sh_b, sh_c;
  logic [3:0] outs;   // {a,b,c,d}
  logic       valid_q, err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HUNT;
      slot    <= 2'd0;
      sh_a    <= 1'b0;
      sh_b    <= 1'b0;
      sh_c    <= 1'b0;
      outs    <= 4'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Pulses default low so they never stretch, including en=0 cycles.
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bus.en) begin
        case (state)
          HUNT: begin
            if (bus.frame) begin
              sh_a  <= bus.din;
              slot  <= 2'd1;
              state <= SYNC;
            end
          end
          SYNC: begin
            if (slot == 2'd0) begin
              if (bus.frame) begin
                sh_a <= bus.din;
                slot <= 2'd1;
              end else begin
                // Missing strobe: drop alignment.
                err_q <= 1'b1;
                slot  <= 2'd0;
                state <= HUNT;
              end
            end else if (bus.frame) begin
              // Early strobe: abandon the partial frame, this cycle is slot a.
              err_q <= 1'b1;
              sh_a  <= bus.din;
              slot  <= 2'd1;
            end else begin
              case (slot)
                2'd1:    sh_b <= bus.din;
                2'd2:    sh_c <= bus.din;
                default: begin
                  outs    <= {sh_a, sh_b, sh_c, bus.din};
                  valid_q <= 1'b1;
                end
              endcase
              slot <= slot + 2'd1;  // 3 wraps to 0
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.out_a  = outs[3];
  assign bus.out_b  = outs[2];
  assign bus.out_c  = outs[1];
  assign bus.out_d  = outs[0];
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.locked = (state == SYNC);
  // mux4 encoding is the bit-reversed slot index; forced to 00 while hunting.
  assign bus.sel    = (state == SYNC) ? {slot[0], slot[1]} : 2'b00;

endmodule
